// File: rtl/spu_mul_pkg.sv
// spu_mul_pkg: shared opcodes and default geometry
// for the SPU SIMD halfword multiplier.
package spu_mul_pkg;

  typedef enum logic [2:0] {
    MPY    = 3'd0,
    MPYU   = 3'd1,
    MPYH   = 3'd2,
    MPYS   = 3'd3,
    MPYHH  = 3'd4,
    MPYHHU = 3'd5,
    MPYI   = 3'd6,
    MPYUI  = 3'd7
  } mul_op_e;

  localparam int SPU_LANES   = 4;
  localparam int SPU_LANE_W  = 32;
  localparam int SPU_LATENCY = 7;
  localparam int SPU_TAG_W   = 7;

endpackage

// File: rtl/spu_mul_lane.sv
// spu_mul_lane: combinational halfword multiply
// for a single word lane.
module spu_mul_lane
  import spu_mul_pkg::*;
#(
  parameter int LANE_W = SPU_LANE_W
) (
  input  logic [LANE_W-1:0] ra,
  input  logic [LANE_W-1:0] rb,
  input  logic [9:0]        imm,
  input  mul_op_e           op,
  output logic [LANE_W-1:0] rt
);

  localparam int HALF = LANE_W / 2;

  logic [HALF-1:0]   w_alo;
  logic [HALF-1:0]   w_ahi;
  logic [HALF-1:0]   w_blo;
  logic [HALF-1:0]   w_bhi;
  logic [HALF-1:0]   w_immh;
  logic [31:0]       w_imm32;
  logic [LANE_W-1:0] w_ss;
  logic [LANE_W-1:0] w_uu;
  logic [LANE_W-1:0] w_hl;
  logic [LANE_W-1:0] w_hhs;
  logic [LANE_W-1:0] w_hhu;
  logic [LANE_W-1:0] w_is;
  logic [LANE_W-1:0] w_iu;
  logic signed [LANE_W-1:0] w_ss_s;

  function automatic logic [LANE_W-1:0] sx(
    input logic [HALF-1:0] x
  );
    return {{HALF{x[HALF-1]}}, x};
  endfunction

  function automatic logic [LANE_W-1:0] zx(
    input logic [HALF-1:0] x
  );
    return {{HALF{1'b0}}, x};
  endfunction

  assign w_alo = ra[HALF-1:0];
  assign w_ahi = ra[LANE_W-1:HALF];
  assign w_blo = rb[HALF-1:0];
  assign w_bhi = rb[LANE_W-1:HALF];

  // Immediate is sign-extended (or narrowed) to exactly HALF bits.
  assign w_imm32 = {{22{imm[9]}}, imm};
  assign w_immh  = w_imm32[HALF-1:0];

  // HALF x HALF products fit exactly in LANE_W bits.
  assign w_ss  = sx(w_alo) * sx(w_blo);
  assign w_uu  = zx(w_alo) * zx(w_blo);
  assign w_hl  = zx(w_ahi) * zx(w_blo);
  assign w_hhs = sx(w_ahi) * sx(w_bhi);
  assign w_hhu = zx(w_ahi) * zx(w_bhi);
  assign w_is  = sx(w_alo) * sx(w_immh);
  assign w_iu  = zx(w_alo) * zx(w_immh);

  assign w_ss_s = $signed(w_ss);

  always_comb begin
    rt = '0;
    unique case (op)
      MPY:    rt = w_ss;
      MPYU:   rt = w_uu;
      MPYH:   rt = w_hl << HALF;
      MPYS:   rt = w_ss_s >>> HALF;
      MPYHH:  rt = w_hhs;
      MPYHHU: rt = w_hhu;
      MPYI:   rt = w_is;
      MPYUI:  rt = w_iu;
      default: rt = '0;
    endcase
  end

endmodule

// File: rtl/spu_mul_pipe.sv
// spu_mul_pipe: LANES-wide halfword multiplier with a
// fixed-latency valid/tag/data pipe, stall and flush.
module spu_mul_pipe
  import spu_mul_pkg::*;
#(
  parameter int LANES   = SPU_LANES,
  parameter int LANE_W  = SPU_LANE_W,
  parameter int LATENCY = SPU_LATENCY,
  parameter int TAG_W   = SPU_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [2:0]              op,
  input  logic [LANES*LANE_W-1:0] ra,
  input  logic [LANES*LANE_W-1:0] rb,
  input  logic [9:0]              imm,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [TAG_W-1:0]        out_tag,
  output logic [LANES*LANE_W-1:0] rt,
  output logic                    busy
);

  localparam int VW = LANES * LANE_W;

  mul_op_e         w_op;
  logic [VW-1:0]   w_prod;

  logic [LATENCY-1:0] r_vld;
  logic [TAG_W-1:0]   r_tag [LATENCY];
  logic [VW-1:0]      r_dat [LATENCY];

  assign w_op = mul_op_e'(op);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    spu_mul_lane #(
      .LANE_W (LANE_W)
    ) u_lane (
      .ra  (ra[g*LANE_W +: LANE_W]),
      .rb  (rb[g*LANE_W +: LANE_W]),
      .imm (imm),
      .op  (w_op),
      .rt  (w_prod[g*LANE_W +: LANE_W])
    );
  end

  // Flush beats stall; stall freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i] <= '0;
        r_dat[i] <= '0;
      end
    end else if (flush) begin
      r_vld <= '0;
    end else if (!stall) begin
      r_vld    <= {r_vld[LATENCY-2:0], in_valid};
      r_tag[0] <= in_tag;
      r_dat[0] <= w_prod;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign out_valid = r_vld[LATENCY-1];
  assign out_tag   = r_tag[LATENCY-1];
  assign rt        = r_dat[LATENCY-1];
  assign busy      = |r_vld;

endmodule

// File: tb/tb_spu_mul_pipe.sv
// tb_spu_mul_pipe: directed checks of the default pipe
// plus a model sweep of a 2-lane, 16-bit, latency-2 pipe.
module tb_spu_mul_pipe;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [2:0]   op;
  logic [127:0] ra;
  logic [127:0] rb;
  logic [9:0]   imm;
  logic [6:0]   in_tag;
  logic         stall;
  logic         flush;
  logic         out_valid;
  logic [6:0]   out_tag;
  logic [127:0] rt;
  logic         busy;

  logic         v2;
  logic [2:0]   op2;
  logic [31:0]  ra2;
  logic [31:0]  rb2;
  logic [9:0]   imm2;
  logic [6:0]   tag2;
  logic         ov2;
  logic [6:0]   ot2;
  logic [31:0]  rt2;
  logic         busy2;
  logic         zero;

  int n_chk;
  int n_bad;

  spu_mul_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .ra        (ra),
    .rb        (rb),
    .imm       (imm),
    .in_tag    (in_tag),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .rt        (rt),
    .busy      (busy)
  );

  spu_mul_pipe #(
    .LANES   (2),
    .LANE_W  (16),
    .LATENCY (2),
    .TAG_W   (7)
  ) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v2),
    .op        (op2),
    .ra        (ra2),
    .rb        (rb2),
    .imm       (imm2),
    .in_tag    (tag2),
    .stall     (zero),
    .flush     (zero),
    .out_valid (ov2),
    .out_tag   (ot2),
    .rt        (rt2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for one 16-bit lane (HALF = 8).
  function automatic logic [15:0] ref16(
    input logic [2:0]  o,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [9:0]  im
  );
    byte sal, sah, sbl, sbh, sim;
    int  p;
    sal = a[7:0];
    sah = a[15:8];
    sbl = b[7:0];
    sbh = b[15:8];
    sim = im[7:0];
    case (o)
      3'd0:    p = sal * sbl;
      3'd1:    p = int'(a[7:0]) * int'(b[7:0]);
      3'd2:    p = (int'(a[15:8]) * int'(b[7:0])) << 8;
      3'd3:    p = (sal * sbl) >>> 8;
      3'd4:    p = sah * sbh;
      3'd5:    p = int'(a[15:8]) * int'(b[15:8]);
      3'd6:    p = sal * sim;
      default: p = int'(a[7:0]) * int'(im[7:0]);
    endcase
    return p[15:0];
  endfunction

  task automatic run_op(
    input string        nm,
    input logic [2:0]   o,
    input logic [127:0] a,
    input logic [127:0] b,
    input logic [9:0]   im,
    input logic [6:0]   t,
    input logic [127:0] e
  );
    int n;
    op       = o;
    ra       = a;
    rb       = b;
    imm      = im;
    in_tag   = t;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ra       = '0;
    rb       = '0;
    n        = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_lat"}, n, 7);
    chk({nm, "_rt"}, rt, e);
    chk({nm, "_tag"}, out_tag, t);
    step();
  endtask

  initial begin
    logic [127:0] e_q [$];
    logic [6:0]   t_q [$];
    logic [31:0]  e2;
    logic         seen;
    n_chk    = 0;
    n_bad    = 0;
    zero     = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = '0;
    ra       = '0;
    rb       = '0;
    imm      = '0;
    in_tag   = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    v2       = 1'b0;
    op2      = '0;
    ra2      = '0;
    rb2      = '0;
    imm2     = '0;
    tag2     = '0;
    #2;
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rt", rt, 0);
    chk("rst_tag", out_tag, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    run_op("mpy", 3'd0, {96'h0, 32'h0000_FFFF} | (128'h3 << 32),
           {96'h0, 32'h0000_0002} | (128'h4 << 32), 10'h0, 7'h15,
           {64'h0, 32'h0000_000C, 32'hFFFF_FFFE});
    run_op("mpyu", 3'd1, {96'h0, 32'h0000_FFFF},
           {96'h0, 32'h0000_0002}, 10'h0, 7'h22,
           {96'h0, 32'h0001_FFFE});
    run_op("mpys", 3'd3, {96'h0, 32'h1234_8000},
           {96'h0, 32'h5678_4000}, 10'h0, 7'h33,
           {96'h0, 32'hFFFF_E000});
    run_op("mpyh", 3'd2, {96'h0, 32'h0003_0000},
           {96'h0, 32'h0000_0005}, 10'h0, 7'h44,
           {96'h0, 32'h000F_0000});
    run_op("mpyi", 3'd6, {96'h0, 32'h0000_0003},
           {96'h0, 32'hFFFF_FFFF}, 10'h3FF, 7'h55,
           {96'h0, 32'hFFFF_FFFD});
    run_op("mpyui", 3'd7, {96'h0, 32'h0000_0002},
           {96'h0, 32'h0}, 10'h3FF, 7'h56,
           {96'h0, 32'h0001_FFFE});
    run_op("mpyhh", 3'd4, {96'h0, 32'hFFFE_0000},
           {96'h0, 32'h0003_0000}, 10'h0, 7'h57,
           {96'h0, 32'hFFFF_FFFA});
    run_op("mpyhhu", 3'd5, {96'h0, 32'hFFFF_0000},
           {96'h0, 32'h0002_0000}, 10'h0, 7'h58,
           {96'h0, 32'h0001_FFFE});

    // Four back-to-back issues with a 3-edge stall after the second.
    op = 3'd1;
    for (int e = 0; e < 16; e++) begin
      logic [6:0] t;
      logic       ev;
      t        = (e == 0) ? 7'd1 : (e == 1) ? 7'd2 :
                 (e <= 5) ? 7'd3 : 7'd4;
      stall    = (e >= 2 && e <= 4);
      in_valid = (e <= 6);
      in_tag   = t;
      ra       = {96'h0, 25'h0, t};
      rb       = {96'h0, 32'h1};
      step();
      ev = (e >= 9 && e <= 12);
      chk("stl_v", out_valid, ev);
      if (ev) begin
        chk("stl_tag", out_tag, e - 8);
        chk("stl_rt", rt, e - 8);
      end
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    step();

    // Three issues, then flush with a same-cycle issue.
    for (int e = 0; e < 4; e++) begin
      in_valid = 1'b1;
      in_tag   = 7'(e + 10);
      flush    = (e == 3);
      step();
      if (e == 2) chk("fl_busy_pre", busy, 1);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_ov", out_valid, 0);
    seen = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("fl_none", seen, 0);

    // Async reset in the middle of an operation.
    op       = 3'd1;
    ra       = {96'h0, 32'h7};
    rb       = {96'h0, 32'h7};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_ov", out_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    run_op("post_rst", 3'd1, {96'h0, 32'h0000_0009},
           {96'h0, 32'h0000_000B}, 10'h0, 7'h61,
           {96'h0, 32'h0000_0063});

    // Narrow instance: random back-to-back ops, latency 2.
    for (int i = 0; i < 24; i++) begin
      op2  = 3'($urandom_range(0, 7));
      ra2  = $urandom;
      rb2  = $urandom;
      imm2 = 10'($urandom);
      tag2 = 7'(i);
      v2   = 1'b1;
      e2   = {ref16(op2, ra2[31:16], rb2[31:16], imm2),
              ref16(op2, ra2[15:0], rb2[15:0], imm2)};
      e_q.push_back({96'h0, e2});
      t_q.push_back(tag2);
      step();
      if (i == 0) begin
        chk("sw_first", ov2, 0);
      end else begin
        chk("sw_v", ov2, 1);
        chk("sw_rt", rt2, e_q.pop_front());
        chk("sw_tag", ot2, t_q.pop_front());
      end
    end
    v2 = 1'b0;
    step();
    chk("sw_v_last", ov2, 1);
    chk("sw_rt_last", rt2, e_q.pop_front());
    chk("sw_tag_last", ot2, t_q.pop_front());
    step();
    chk("sw_drain", ov2, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spu_mul_pipe.md
# spu_mul_pipe

Parametrised, pipelined SIMD halfword multiplier for the SPU odd/even execution pipe. It accepts one instruction per cycle across LANES word lanes and supports eight multiply opcodes, including signed/unsigned, high-half and immediate forms. Results emerge after a fixed LATENCY with a destination tag. Stall freezes the pipe; flush kills in-flight operations. The block sits between the operand-fetch stage and the register-file writeback arbiter.

## Interface
- LANES, 4, number of word lanes
- LANE_W, 32, lane width in bits; must be even; HALF = LANE_W/2
- LATENCY, 7, cycles from input sample to result; legal range 2..16
- TAG_W, 7, destination register tag width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset; one clock domain, no other clocks
- in_valid  input  1  issue strobe; sampled only when stall=0
- op  input  3  opcode (see Operation)
- ra, rb  input  LANES*LANE_W  operands; lane i = bits [i*LANE_W +: LANE_W]
- imm  input  10  immediate for MPYI/MPYUI
- in_tag  input  TAG_W  destination tag
- stall  input  1  freeze all stages
- flush  input  1  invalidate all in-flight operations
- out_valid  output  1  result valid this cycle
- out_tag  output  TAG_W  tag of the result
- rt  output  LANES*LANE_W  result vector
- busy  output  1  OR of all stage valid bits

## Operation
- Per lane: lo = a[HALF-1:0], hi = a[LANE_W-1:HALF]. All products are computed at 2*HALF = LANE_W bits, and results are truncated to LANE_W.
- 0 MPY: signed lo(ra) * signed lo(rb).
- 1 MPYU: unsigned lo * lo.
- 2 MPYH: (unsigned hi(ra) * lo(rb)) << HALF. The low HALF bits are zero.
- 3 MPYS: signed lo * lo, arithmetic >> HALF, sign-extended to LANE_W.
- 4 MPYHH: signed hi * hi.
- 5 MPYHHU: unsigned hi * hi.
- 6 MPYI: signed lo(ra) * imm sign-extended to HALF.
- 7 MPYUI: imm is sign-extended to HALF, then used in an unsigned multiply by lo(ra).
- The rb operand is ignored for ops 6 and 7.
- Stage 1 registers the per-lane products, the tag and the valid bit. Stages 2..LATENCY delay these values unchanged.
- Stage valid bits reset to 0. Stage data resets to 0, and data is don't-care when the matching valid bit is 0.
- Flushed or bubble slots never assert out_valid.

## Timing
- Reset values: out_valid=0, busy=0, rt=0, out_tag=0. Reset takes effect immediately, with no clock required.
- Latency: an input sampled at edge k (in_valid=1, stall=0) appears with out_valid=1 after edge k+LATENCY-1. The output is visible for the cycle after that edge.
- Throughput is one operation per non-stalled cycle. There is no backpressure beyond stall.
- While stall=1:
  - All stage registers, including the output, hold their values.
  - in_valid is ignored.
  - out_valid keeps its held value. The consumer must gate writeback with stall.
- flush=1 at an edge clears every stage valid bit, including the output stage. The same-cycle in_valid is dropped, so out_valid=0 from the next cycle.
- flush and stall asserted together: flush wins.
- Back-to-back issue with no stall produces back-to-back out_valid with no bubble.
- Reset asserted mid-operation discards all in-flight results. The first valid output after release comes LATENCY cycles after the first post-reset issue.

## Structure
- Package spu_mul_pkg:
  - mul_op_e enum (MPY..MPYUI, 3 bits).
  - Default localparams for LANES, LANE_W and LATENCY.
- Sub-module spu_mul_lane:
  - Combinational.
  - Inputs: one lane of ra and rb, plus imm and op.
  - Output: the LANE_W-bit result.
  - Instantiated LANES times via generate.
- Top level holds the valid/tag/data shift pipeline and the stall/flush control.

## Test plan
- Reset, then MPY with lane0 ra=0x0000_FFFF and rb=0x0000_0002 -> lane0 rt=0xFFFF_FFFE after 7 cycles; out_tag matches in_tag.
- MPYU with the same operands -> 0x0001_FFFE. MPYS with lo(ra)=0x8000, lo(rb)=0x4000 -> 0xFFFF_E000.
- MPYH with ra=0x0003_0000 and rb=0x0000_0005 -> 0x000F_0000. MPYI with lo(ra)=3 and imm=0x3FF -> 0xFFFF_FFFD.
- Issue 4 back-to-back ops with tags 1..4 and assert stall for 3 cycles mid-stream -> outputs arrive in order with no loss or duplication, and each is delayed by exactly 3 cycles.
- Issue 3 ops, then assert flush and in_valid together on the fourth cycle -> no out_valid ever appears for them; busy=0 on the next cycle.
- Parameter sweep with LANES=2, LANE_W=16, LATENCY=2 -> random ops match a reference model, with results exactly 2 cycles after issue.
